// File: rtl/entropy_harvester.sv
// rtl/entropy_harvester.sv - freeze/sample entropy harvester with repetition health test and byte FIFO
// Optional von Neumann debiasing is compiled in with ENTROPY_HARVESTER_VN_EN.
module entropy_harvester #(
  parameter int SAMPLE_DIV = 16,
  parameter int FREEZE_CYC = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] raw_in,
  output logic        freeze_out,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        health_fail,
  output logic        overrun
);

  localparam int PH_MAX = (SAMPLE_DIV > FREEZE_CYC) ? SAMPLE_DIV : FREEZE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic {WAIT_ST, HOLD_ST} state_t;

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [15:0]       prev_word;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_next;
  logic [7:0]        shreg;
  logic [3:0]        bit_cnt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  logic capture, fold_bit, trip, accept, emit_valid, emit_bit;
  logic push_req, push, pop, full;

  assign capture  = en && (state == HOLD_ST) && (phase == PH_W'(FREEZE_CYC - 1));
  assign fold_bit = ^raw_in;

  // rep_cnt == 0 marks "no previous capture since reset"
  always_comb begin
    rep_next = REP_W'(1);
    if (rep_cnt != '0 && raw_in == prev_word) begin
      rep_next = (rep_cnt == REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + REP_W'(1);
    end
  end

  assign trip   = capture && (rep_next >= REP_W'(REP_LIMIT));
  assign accept = capture && !health_fail && !trip;

`ifdef ENTROPY_HARVESTER_VN_EN
  logic pair_have, pair_bit;
  assign emit_valid = accept && pair_have && (pair_bit != fold_bit);
  assign emit_bit   = pair_bit;
`else
  assign emit_valid = accept;
  assign emit_bit   = fold_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= WAIT_ST;
      phase      <= '0;
      freeze_out <= 1'b0;
    end else if (state == WAIT_ST) begin
      if (phase == PH_W'(SAMPLE_DIV - 1)) begin
        state      <= HOLD_ST;
        phase      <= '0;
        freeze_out <= 1'b1;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end else begin
      if (phase == PH_W'(FREEZE_CYC - 1)) begin
        state      <= WAIT_ST;
        phase      <= '0;
        freeze_out <= 1'b0;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_word   <= '0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (capture) begin
      prev_word <= raw_in;
      rep_cnt   <= rep_next;
      if (trip) health_fail <= 1'b1;
    end
  end

  // bit_cnt == 8 means a full byte waits one cycle for its FIFO push
  always_ff @(posedge clk) begin
    if (rst || health_fail || trip) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_cnt == 4'd8) begin
      bit_cnt <= '0;
    end else if (emit_valid) begin
      shreg   <= {shreg[6:0], emit_bit};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

`ifdef ENTROPY_HARVESTER_VN_EN
  always_ff @(posedge clk) begin
    if (rst || health_fail || trip || !en) begin
      pair_have <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (accept) begin
      pair_have <= !pair_have;
      if (!pair_have) pair_bit <= fold_bit;
    end
  end
`endif

  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign push_req  = (bit_cnt == 4'd8) && !health_fail;
  assign push      = push_req && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_req && full && !pop) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

endmodule
